// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one 8N1 UART transmitter among requesters
module uart_tx_arbiter #(
  parameter int Clock = 50,
  parameter int Baud  = 115200,
  parameter int Ports = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [Ports-1:0]           req_valid,
  input  logic [8*Ports-1:0]         req_data,
  output logic [Ports-1:0]           req_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(Ports)-1:0]   grant_id
);

  localparam int          IW  = $clog2(Ports);
  localparam int unsigned DIV = (Clock * 1000000) / Baud;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   sel;
  logic            found;
  logic [7:0]      sel_byte;
  logic [7:0]      shreg;
  logic [2:0]      bit_cnt;
  logic [31:0]     baud_cnt;
  logic            wrap;

  assign wrap = (baud_cnt == DIV - 1);
  assign busy = (state != IDLE);

  // Round-robin search: first valid requester at or after ptr, wrapping modulo Ports.
  always_comb begin
    int idx;
    logic [IW-1:0] cand;
    found    = 1'b0;
    sel      = '0;
    sel_byte = '0;
    idx      = 0;
    cand     = '0;
    for (int k = 0; k < Ports; k++) begin
      idx  = (int'(ptr) + k) % Ports;
      cand = IW'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    for (int k = 0; k < Ports; k++) begin
      if (sel == IW'(k)) sel_byte = req_data[8*k +: 8];
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found && !rst) req_ready[sel] = 1'b1;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (found) state_n = START;
      START:   if (wrap) state_n = DATA;
      DATA:    if (wrap && bit_cnt == 3'd7) state_n = STOP;
      STOP:    if (wrap) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx       <= 1'b1;
      grant_id <= '0;
      ptr      <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        shreg    <= sel_byte;
        grant_id <= sel;
        ptr      <= (sel == IW'(Ports - 1)) ? '0 : sel + 1'b1;
        bit_cnt  <= '0;
        baud_cnt <= '0;
        tx       <= 1'b0;
      end
    end else begin
      baud_cnt <= wrap ? '0 : baud_cnt + 32'd1;
      // tx is updated on the wrap so each level holds exactly DIV cycles.
      if (wrap) begin
        case (state)
          START: tx <= shreg[0];
          DATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) tx <= 1'b1;
            else                 tx <= shreg[bit_cnt + 3'd1];
          end
          default: tx <= 1'b1;
        endcase
      end
    end
  end

endmodule
